// File: rtl/microsequencer_param.sv
// Microprogram sequencer: next microaddress from op/condition/branch field, with call stack and loop counter.
// Latency: inputs sampled on a rising edge set o_address for the following cycle; one op per cycle, no bubbles.
// Backpressure: none; every op completes in one cycle; stack over/underflow is absorbed and reported via sticky flags.
module microsequencer_param #(
  parameter int AW          = 12,
  parameter int STACK_DEPTH = 4,
  parameter int CNT_W       = 8,
  parameter int NCOND       = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [2:0]               i_op,
  input  logic [$clog2(NCOND)-1:0] i_cond_sel,
  input  logic                     i_cond_pol,
  input  logic [NCOND-1:0]         i_cond_in,
  input  logic [AW-1:0]            i_d_in,
  input  logic                     i_relative,
  input  logic                     i_cnt_load,
  input  logic [CNT_W-1:0]         i_cnt_value,
  output logic [AW-1:0]            o_address,
  output logic                     o_count_zero,
  output logic                     o_stack_empty,
  output logic                     o_stack_overflow,
  output logic                     o_stack_underflow
);

  // Op encodings as driven by the pipeline register.
  localparam logic [2:0] OP_CONT = 3'd0;
  localparam logic [2:0] OP_JUMP = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_LOOP = 3'd4;
  localparam logic [2:0] OP_MAP  = 3'd5;
  localparam logic [2:0] OP_HOLD = 3'd6;

  localparam int CSW = $clog2(NCOND);
  // Stack pointer must represent 0..STACK_DEPTH inclusive.
  localparam int SPW = $clog2(STACK_DEPTH + 1);
  localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [SPW-1:0] SP_FULL   = SPW'(STACK_DEPTH);
  localparam logic [CSW:0]   NCOND_LIM = (CSW + 1)'(NCOND);

  // Architectural state.
  logic [AW-1:0]    r_address;
  logic [SPW-1:0]   r_sp;
  logic [CNT_W-1:0] r_cnt;
  logic             r_overflow;
  logic             r_underflow;
  logic [AW-1:0]    r_stack [STACK_DEPTH];

  // Combinational decode results.
  logic             w_cond_raw;
  logic             w_cond;
  logic [AW-1:0]    w_inc;
  logic [AW-1:0]    w_target;
  logic             w_sp_full;
  logic             w_sp_empty;
  logic             w_cnt_nz;
  logic [IW-1:0]    w_push_idx;
  logic [IW-1:0]    w_pop_idx;
  logic [AW-1:0]    w_next;
  logic             w_push;
  logic             w_pop;
  logic             w_ovf_set;
  logic             w_unf_set;
  logic             w_cnt_dec;

  // Select one condition input; out-of-range selects read as false before polarity.
  always_comb begin
    w_cond_raw = 1'b0;
    if ({1'b0, i_cond_sel} < NCOND_LIM) begin
      w_cond_raw = i_cond_in[i_cond_sel];
    end
  end

  assign w_cond     = w_cond_raw ^ i_cond_pol;
  // Adders wrap modulo 2^AW; a relative d_in is treated as two's complement by the same wrap.
  assign w_inc      = r_address + AW'(1);
  assign w_target   = i_relative ? (r_address + i_d_in) : i_d_in;
  assign w_sp_full  = (r_sp == SP_FULL);
  assign w_sp_empty = (r_sp == '0);
  assign w_cnt_nz   = (r_cnt != '0);
  // Push writes the slot at sp; pop reads the slot just below it.
  assign w_push_idx = IW'(r_sp);
  assign w_pop_idx  = IW'(r_sp - SPW'(1));

  // Next-address selection and stack/counter side effects per op.
  always_comb begin
    w_next    = w_inc;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    w_cnt_dec = 1'b0;
    case (i_op)
      OP_CONT: begin
        w_next = w_inc;
      end
      OP_JUMP: begin
        if (w_cond) begin
          w_next = w_target;
        end
      end
      OP_CALL: begin
        // A taken call always jumps; the return address is dropped if the stack is full.
        if (w_cond) begin
          w_next = w_target;
          if (w_sp_full) begin
            w_ovf_set = 1'b1;
          end else begin
            w_push = 1'b1;
          end
        end
      end
      OP_RET: begin
        // A taken return on an empty stack falls through instead of using stale data.
        if (w_cond) begin
          if (w_sp_empty) begin
            w_unf_set = 1'b1;
          end else begin
            w_pop  = 1'b1;
            w_next = r_stack[w_pop_idx];
          end
        end
      end
      OP_LOOP: begin
        // Branch decision uses the counter value held at the start of this cycle.
        if (w_cnt_nz) begin
          w_next    = w_target;
          w_cnt_dec = 1'b1;
        end
      end
      OP_MAP: begin
        w_next = i_d_in;
      end
      OP_HOLD: begin
        w_next = r_address;
      end
      default: begin
        w_next = w_inc;
      end
    endcase
  end

  // Microaddress register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_address <= '0;
    end else begin
      r_address <= w_next;
    end
  end

  // Stack pointer moves by at most one entry per cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sp <= '0;
    end else if (w_push) begin
      r_sp <= r_sp + SPW'(1);
    end else if (w_pop) begin
      r_sp <= r_sp - SPW'(1);
    end
  end

  // Stack storage is unreset; only entries below sp are ever read.
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_stack[w_push_idx] <= w_inc;
    end
  end

  // Loop counter: an explicit load wins over a same-cycle decrement.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_cnt_load) begin
      r_cnt <= i_cnt_value;
    end else if (w_cnt_dec) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign o_address         = r_address;
  assign o_count_zero      = ~w_cnt_nz;
  assign o_stack_empty     = w_sp_empty;
  assign o_stack_overflow  = r_overflow;
  assign o_stack_underflow = r_underflow;

endmodule

// File: tb/tb_microsequencer_param.sv
// Bench for microsequencer_param: directed scenarios then random ops against a queue-based model.
// Latency: each step drives inputs, waits one rising edge, then compares outputs 1 time unit later.
// Backpressure: not applicable; one op per clock.
module tb_microsequencer_param;

  logic        clock;
  logic        reset;
  logic [2:0]  i_op;
  logic [2:0]  i_cond_sel;
  logic        i_cond_pol;
  logic [7:0]  i_cond_in;
  logic [11:0] i_d_in;
  logic        i_relative;
  logic        i_cnt_load;
  logic [7:0]  i_cnt_value;
  logic [11:0] o_address;
  logic        o_count_zero;
  logic        o_stack_empty;
  logic        o_stack_overflow;
  logic        o_stack_underflow;

  microsequencer_param #(
    .AW(12), .STACK_DEPTH(4), .CNT_W(8), .NCOND(8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .i_op             (i_op),
    .i_cond_sel       (i_cond_sel),
    .i_cond_pol       (i_cond_pol),
    .i_cond_in        (i_cond_in),
    .i_d_in           (i_d_in),
    .i_relative       (i_relative),
    .i_cnt_load       (i_cnt_load),
    .i_cnt_value      (i_cnt_value),
    .o_address        (o_address),
    .o_count_zero     (o_count_zero),
    .o_stack_empty    (o_stack_empty),
    .o_stack_overflow (o_stack_overflow),
    .o_stack_underflow(o_stack_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks;
  int errors;
  int step_no;

  // Reference model state: plain integers and a queue as the return stack.
  int m_addr;
  int m_cnt;
  int m_ovf;
  int m_unf;
  int m_stk[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("address", {20'd0, o_address}, m_addr);
    chk("count_zero", {31'd0, o_count_zero}, (m_cnt == 0) ? 1 : 0);
    chk("stack_empty", {31'd0, o_stack_empty}, (m_stk.size() == 0) ? 1 : 0);
    chk("overflow", {31'd0, o_stack_overflow}, m_ovf);
    chk("underflow", {31'd0, o_stack_underflow}, m_unf);
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_cnt  = 0;
    m_ovf  = 0;
    m_unf  = 0;
    m_stk.delete();
  endtask

  // One op: drive, predict from the rules, clock, compare.
  task automatic step(input int op, input int sel, input int pol, input int cin,
                      input int d, input int rel, input int ld, input int val);
    int cond;
    int tgt;
    int inc;
    int nxt;
    int ncnt;
    i_op        = 3'(op);
    i_cond_sel  = 3'(sel);
    i_cond_pol  = 1'(pol);
    i_cond_in   = 8'(cin);
    i_d_in      = 12'(d);
    i_relative  = 1'(rel);
    i_cnt_load  = 1'(ld);
    i_cnt_value = 8'(val);
    cond = ((sel < 8) ? ((cin >> sel) & 1) : 0) ^ pol;
    tgt  = rel ? ((m_addr + d) % 4096) : d;
    inc  = (m_addr + 1) % 4096;
    nxt  = inc;
    ncnt = m_cnt;
    case (op)
      1: if (cond) nxt = tgt;
      2: if (cond) begin
           nxt = tgt;
           if (m_stk.size() < 4) m_stk.push_back(inc);
           else m_ovf = 1;
         end
      3: if (cond) begin
           if (m_stk.size() > 0) nxt = m_stk.pop_back();
           else m_unf = 1;
         end
      4: if (m_cnt != 0) begin
           nxt  = tgt;
           ncnt = m_cnt - 1;
         end
      5: nxt = d;
      6: nxt = m_addr;
      default: nxt = inc;
    endcase
    if (ld) ncnt = val;
    @(posedge clock);
    #1;
    step_no++;
    m_addr = nxt;
    m_cnt  = ncnt;
    chk_all();
  endtask

  // Shorthands: an always-true condition is sel=0, cond_in=0, pol=1.
  task automatic op_plain(input int op, input int d);
    step(op, 0, 1, 0, d, 0, 0, 0);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    step_no = 0;
    reset   = 1'b1;
    i_op = '0; i_cond_sel = '0; i_cond_pol = 1'b0; i_cond_in = '0;
    i_d_in = '0; i_relative = 1'b0; i_cnt_load = 1'b0; i_cnt_value = '0;
    model_reset();
    #12;
    chk_all();
    chk("reset_addr", {20'd0, o_address}, 32'h0);
    reset = 1'b0;

    // Sequential fetch from reset.
    for (int i = 1; i <= 5; i++) begin
      op_plain(0, 0);
      chk("cont_seq", {20'd0, o_address}, i);
    end

    // Address wrap and relative branch with negative offset.
    op_plain(5, 'hFFF);
    op_plain(0, 0);
    chk("wrap", {20'd0, o_address}, 32'h000);
    op_plain(5, 'h010);
    step(1, 0, 1, 0, 'hFFE, 1, 0, 0);
    chk("rel_jump", {20'd0, o_address}, 32'h00E);

    // Condition select and polarity.
    op_plain(5, 'h020);
    step(1, 2, 0, 'b0000_0100, 'h080, 0, 0, 0);
    chk("cond_pol0", {20'd0, o_address}, 32'h080);
    step(1, 2, 1, 'b0000_0100, 'h100, 0, 0, 0);
    chk("cond_pol1", {20'd0, o_address}, 32'h081);
    step(2, 3, 0, 'b0000_0100, 'h200, 0, 0, 0);
    chk("call_untaken", {20'd0, o_address}, 32'h082);

    // Nested calls, overflow, returns, underflow.
    op_plain(5, 'h010);
    op_plain(2, 'h020);
    op_plain(2, 'h030);
    op_plain(2, 'h040);
    op_plain(2, 'h050);
    op_plain(2, 'h060);
    chk("ovf_jump", {20'd0, o_address}, 32'h060);
    chk("ovf_flag", {31'd0, o_stack_overflow}, 32'd1);
    op_plain(3, 0);
    chk("ret1", {20'd0, o_address}, 32'h041);
    op_plain(3, 0);
    chk("ret2", {20'd0, o_address}, 32'h031);
    op_plain(3, 0);
    chk("ret3", {20'd0, o_address}, 32'h021);
    op_plain(3, 0);
    chk("ret4", {20'd0, o_address}, 32'h011);
    op_plain(3, 0);
    chk("unf_inc", {20'd0, o_address}, 32'h012);
    chk("unf_flag", {31'd0, o_stack_underflow}, 32'd1);

    // Loop of three iterations, then fall-through.
    step(5, 0, 0, 0, 'h052, 0, 1, 3);
    for (int k = 0; k < 3; k++) begin
      op_plain(4, 'h050);
      chk("loop_taken", {20'd0, o_address}, 32'h050);
      op_plain(0, 0);
      op_plain(0, 0);
    end
    op_plain(4, 'h050);
    chk("loop_exit", {20'd0, o_address}, 32'h053);
    chk("loop_cz", {31'd0, o_count_zero}, 32'd1);
    // Load and LOOP together at counter zero.
    step(4, 0, 0, 0, 'h050, 0, 1, 5);
    chk("ld_loop_addr", {20'd0, o_address}, 32'h054);
    chk("ld_loop_cz", {31'd0, o_count_zero}, 32'd0);

    // Asynchronous reset in the middle of a call chain.
    op_plain(2, 'h100);
    op_plain(2, 'h200);
    reset = 1'b1;
    #1;
    model_reset();
    chk_all();
    chk("arst_addr", {20'd0, o_address}, 32'h0);
    #2;
    reset = 1'b0;

    // Randomized ops against the model.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 1),
           $urandom_range(0, 255), $urandom_range(0, 4095), $urandom_range(0, 1),
           ($urandom_range(0, 7) == 0) ? 1 : 0, $urandom_range(0, 6));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
